// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide single-port memory between the instruction-fetch and data ports.
// Each 32-bit word access is sequenced as four byte transfers; MEM wins arbitration over IF.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BIT_NUMBER = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic [4*BIT_NUMBER-1:0] if_rdata,
    output logic                    if_ready,
    output logic                    if_freeze,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [4*BIT_NUMBER-1:0] mem_wdata,
    output logic [4*BIT_NUMBER-1:0] mem_rdata,
    output logic                    mem_ready,
    output logic                    mem_freeze,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [BIT_NUMBER-1:0]   sram_wdata,
    output logic                    sram_we,
    output logic                    sram_re,
    input  logic [BIT_NUMBER-1:0]   sram_rdata
);

    localparam int          NBYTES = 4;
    localparam int unsigned WORD_W = 4 * BIT_NUMBER;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_t;
    typedef enum logic {GNT_IF, GNT_MEM} grant_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    state_t              state_q, state_d;
    grant_t              grant_q, grant_d;
    op_t                 op_q, op_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          k_q, k_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [BIT_NUMBER-1:0] sram_wdata_q, sram_wdata_d;
    logic                sram_we_q, sram_we_d;
    logic                sram_re_q, sram_re_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_IF;
            op_q         <= OP_RD;
            base_q       <= '0;
            k_q          <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            base_q       <= base_d;
            k_q          <= k_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            sram_re_q    <= sram_re_d;
        end
    end

    // Next-state logic; memory strobes are registered from the next state so they line up with XFER cycles
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        op_d         = op_q;
        base_d       = base_q;
        k_d          = k_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        sram_we_d    = 1'b0;
        sram_re_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_r_en | mem_w_en) begin
                    grant_d = GNT_MEM;
                    op_d    = mem_w_en ? OP_WR : OP_RD;
                    base_d  = mem_addr;
                    wdata_d = mem_wdata;
                    k_d     = '0;
                    asm_d   = '0;
                    state_d = ST_XFER;
                end else if (if_req) begin
                    grant_d = GNT_IF;
                    op_d    = OP_RD;
                    base_d  = if_addr;
                    k_d     = '0;
                    asm_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Data port assembles little-endian, fetch port big-endian
                if (op_q == OP_RD) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (k_q == 2'(i)) begin
                            if (grant_q == GNT_MEM)
                                asm_d[i*BIT_NUMBER +: BIT_NUMBER] = sram_rdata;
                            else
                                asm_d[(NBYTES-1-i)*BIT_NUMBER +: BIT_NUMBER] = sram_rdata;
                        end
                    end
                end
                if (k_q == 2'(NBYTES-1)) begin
                    state_d = ST_DONE;
                    if (grant_q == GNT_MEM) begin
                        mem_ready_d = 1'b1;
                        if (op_q == OP_RD)
                            mem_rdata_d = asm_d;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = asm_d;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_XFER) begin
            sram_addr_d = base_d + ADDR_W'(k_d);
            if (op_d == OP_WR) begin
                sram_we_d = 1'b1;
                for (int i = 0; i < NBYTES; i++) begin
                    if (k_d == 2'(i))
                        sram_wdata_d = wdata_d[i*BIT_NUMBER +: BIT_NUMBER];
                end
            end else begin
                sram_re_d = 1'b1;
            end
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = sram_we_q;
    assign sram_re    = sram_re_q;

    // Stalls must act in the same cycle a request is raised
    assign if_freeze  = if_req & ~if_ready_q;
    assign mem_freeze = (mem_r_en | mem_w_en) & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model, write/ready scoreboards and per-scenario tasks.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BIT_NUMBER = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_freeze;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_freeze;
    logic [31:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_we;
    logic        sram_re;
    logic [7:0]  sram_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .BIT_NUMBER(BIT_NUMBER)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_freeze(if_freeze),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_freeze(mem_freeze),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory model, aliased on the low 8 address bits
    logic [7:0] mem_arr [0:255];
    always @(posedge clk) if (sram_we) mem_arr[sram_addr[7:0]] <= sram_wdata;
    assign sram_rdata = mem_arr[sram_addr[7:0]];

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] if_q[$];
    logic [31:0] last_mem_rd;
    int          errors = 0;
    int          checks = 0;

    // Scoreboard: byte writes and ready pulses are popped against pushed expectations
    always @(negedge clk) begin
        wr_t         e;
        logic [31:0] w;
        if (sram_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL sram_write unexpected addr=%h data=%h", sram_addr, sram_wdata);
            end else begin
                e = wr_q.pop_front();
                if ({sram_addr, sram_wdata} !== e) begin
                    errors++;
                    $display("FAIL sram_write got addr=%h data=%h want addr=%h data=%h",
                             sram_addr, sram_wdata, e.addr, e.data);
                end
            end
        end
        if (mem_ready) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_ready unexpected pulse");
            end else begin
                w = mem_q.pop_front();
                if (mem_rdata !== w) begin
                    errors++;
                    $display("FAIL mem_rdata got %h want %h", mem_rdata, w);
                end
            end
        end
        if (if_ready) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++;
                $display("FAIL if_ready unexpected pulse");
            end else begin
                w = if_q.pop_front();
                if (if_rdata !== w) begin
                    errors++;
                    $display("FAIL if_rdata got %h want %h", if_rdata, w);
                end
            end
        end
    end

    task automatic push_word_writes(input logic [31:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            e.addr = addr + 32'(k);
            e.data = data[8*k +: 8];
            wr_q.push_back(e);
        end
    endtask

    // Returns the number of negedges from request cycle to the ready pulse, -1 on timeout
    task automatic wait_ready(input bit is_if, output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (is_if ? if_ready : mem_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mem_access(input logic r, input logic w, input logic [31:0] addr,
                              input logic [31:0] data, input string name);
        int lat;
        @(posedge clk); #1;
        mem_r_en  = r;
        mem_w_en  = w;
        mem_addr  = addr;
        mem_wdata = data;
        wait_ready(1'b0, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL %s latency got %0d want 5", name, lat);
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; if_req = 0; if_addr = '0;
        mem_r_en = 0; mem_w_en = 0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_rdata, mem_rdata, if_ready, mem_ready, sram_addr, sram_wdata, sram_we, sram_re} !== '0) begin
            errors++;
            $display("FAIL reset_outputs if_rdata=%h mem_rdata=%h rdy=%b%b sram_addr=%h wdata=%h we=%b re=%b",
                     if_rdata, mem_rdata, if_ready, mem_ready, sram_addr, sram_wdata, sram_we, sram_re);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({sram_we, sram_re, if_ready, mem_ready, if_freeze, mem_freeze, sram_addr} !== '0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d we=%b re=%b addr=%h", i, sram_we, sram_re, sram_addr);
            end
        end
        last_mem_rd = '0;
    endtask

    task automatic test_write_read;
        push_word_writes(32'h10, 32'hA1B2C3D4);
        mem_q.push_back(last_mem_rd);
        mem_access(1'b0, 1'b1, 32'h10, 32'hA1B2C3D4, "write_0x10");
        mem_q.push_back(32'hA1B2C3D4);
        mem_access(1'b1, 1'b0, 32'h10, 32'h0, "read_0x10");
        last_mem_rd = 32'hA1B2C3D4;
        checks++;
        if ({mem_arr[8'h13], mem_arr[8'h12], mem_arr[8'h11], mem_arr[8'h10]} !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL mem_bytes_0x10 got %h%h%h%h want a1b2c3d4",
                     mem_arr[8'h13], mem_arr[8'h12], mem_arr[8'h11], mem_arr[8'h10]);
        end
    endtask

    task automatic test_if_fetch;
        mem_arr[8'h20] = 8'hE3;
        mem_arr[8'h21] = 8'hA0;
        mem_arr[8'h22] = 8'h10;
        mem_arr[8'h23] = 8'h05;
        if_q.push_back(32'hE3A01005);
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h20;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_freeze !== (i < 5)) begin
                errors++;
                $display("FAIL if_freeze cycle t+%0d got %b want %b", i, if_freeze, (i < 5));
            end
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++;
            $display("FAIL if_ready_t5 got %b want 1", if_ready);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_simultaneous;
        int mem_lat = -1;
        int if_lat  = -1;
        mem_q.push_back(32'hA1B2C3D4);
        if_q.push_back(32'hE3A01005);
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_addr = 32'h10;
        if_req   = 1'b1; if_addr  = 32'h20;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_ready && mem_lat < 0) mem_lat = i;
            if (if_ready && if_lat < 0) if_lat = i;
            @(posedge clk); #1;
            if (mem_lat >= 0) mem_r_en = 1'b0;
            if (if_lat >= 0) begin
                if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0; mem_r_en = 1'b0;
        checks++;
        if (mem_lat != 5) begin
            errors++;
            $display("FAIL simul_mem_ready got t+%0d want t+5", mem_lat);
        end
        checks++;
        if (if_lat != 11) begin
            errors++;
            $display("FAIL simul_if_ready got t+%0d want t+11", if_lat);
        end
    endtask

    task automatic test_wrap;
        push_word_writes(32'hFFFF_FFFE, 32'h11223344);
        mem_q.push_back(last_mem_rd);
        mem_access(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h11223344, "write_wrap");
        mem_q.push_back(32'h11223344);
        mem_access(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, "read_wrap");
        last_mem_rd = 32'h11223344;
    endtask

    task automatic test_both_enables;
        push_word_writes(32'h40, 32'h55667788);
        mem_q.push_back(last_mem_rd);
        mem_access(1'b1, 1'b1, 32'h40, 32'h55667788, "rw_both");
    endtask

    task automatic test_reset_mid_write;
        wr_t e;
        e.addr = 32'h30; e.data = 8'hEF; wr_q.push_back(e);
        e.addr = 32'h31; e.data = 8'hBE; wr_q.push_back(e);
        @(posedge clk); #1;
        mem_w_en = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_w_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_mem_rd = '0;
        @(negedge clk);
        checks++;
        if ({sram_we, sram_re, sram_addr, mem_ready, mem_rdata} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle we=%b re=%b addr=%h rdy=%b rdata=%h",
                     sram_we, sram_re, sram_addr, mem_ready, mem_rdata);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({mem_arr[8'h33], mem_arr[8'h32], mem_arr[8'h31], mem_arr[8'h30]} !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL abort_bytes got %h%h%h%h want 0000beef",
                     mem_arr[8'h33], mem_arr[8'h32], mem_arr[8'h31], mem_arr[8'h30]);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL abort_writes_missing got %0d pending want 0", wr_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        last_mem_rd = '0;
        test_reset;
        test_write_read;
        test_if_fetch;
        test_simultaneous;
        test_wrap;
        test_both_enables;
        test_reset_mid_write;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_q.size() != 0 || if_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got mem=%0d if=%0d wr=%0d want 0",
                     mem_q.size(), if_q.size(), wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
